// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared raster constants and coordinate helpers for the VGA timing generator
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef logic [COORD_W-1:0] coord_t;

  // Half-open window test done in int so an upper bound of 2**COORD_W cannot wrap.
  function automatic logic in_window(coord_t c, int lo, int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster coordinate, blanking, sync and event bundle for renderers
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t DrawX;
  coord_t DrawY;
  logic   blank;
  logic   blank_d;
  logic   hs;
  logic   vs;
  logic   line_start;
  logic   frame_start;

  modport master (
    output DrawX, DrawY, blank, blank_d, hs, vs, line_start, frame_start
  );

  modport slave (
    input DrawX, DrawY, blank, blank_d, hs, vs, line_start, frame_start
  );

endinterface

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - fixed-depth shift register with synchronous clear to a parameter value
module sync_delay #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters, visible/sync decodes and sync delay matched to the
// two-stage renderer fetch
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = H_VISIBLE_DEF,
  parameter int   H_FRONT     = H_FRONT_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BACK      = H_BACK_DEF,
  parameter int   V_VISIBLE   = V_VISIBLE_DEF,
  parameter int   V_FRONT     = V_FRONT_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BACK      = V_BACK_DEF,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   PIPE_DELAY  = 2
) (
  input logic             vga_clk,
  input logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int VS_START = V_VISIBLE + V_FRONT;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
    $error("vga_timing_gen: raster total exceeds coordinate range");
  end
  if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 1..4");
  end

  coord_t     hc;
  coord_t     vc;
  logic       blank_raw;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] dly_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  assign blank_raw = in_window(hc, 0, H_VISIBLE) && in_window(vc, 0, V_VISIBLE);
  assign hs_raw    = in_window(hc, HS_START, HS_START + H_SYNC);
  assign vs_raw    = in_window(vc, VS_START, VS_START + V_SYNC);

  // Clears to "deasserted" so syncs and blank_d stay idle until real decodes reach the output.
  sync_delay #(
    .DEPTH  (PIPE_DELAY),
    .WIDTH  (3),
    .RST_VAL(3'b000)
  ) u_sync_delay (
    .clk (vga_clk),
    .clr (reset),
    .din ({hs_raw, vs_raw, blank_raw}),
    .dout(dly_q)
  );

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.blank       = blank_raw;
  assign vga.blank_d     = dly_q[0];
  assign vga.hs          = dly_q[2] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vga.vs          = dly_q[1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vga.line_start  = (hc == '0);
  assign vga.frame_start = (hc == '0) && (vc == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: a small-raster instance and a default
// 640x480 instance checked every cycle against an arithmetic raster model
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int AHV = 20, AHF = 3, AHS = 5, AHB = 4;
  localparam int AVV = 12, AVF = 2, AVS = 2, AVB = 3;
  localparam int AHT = AHV + AHF + AHS + AHB;
  localparam int AVT = AVV + AVF + AVS + AVB;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       blank_d;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;

  int  checks   = 0;
  int  failures = 0;
  int  t        = 0;
  bit  valid    = 0;
  bit  measuring = 0;

  int last_fs = -1, blank_cnt = 0, frames = 0;
  int run_ahs = 0, run_avs = 0, run_bhs = 0;

  vga_timing_gen_if a_if ();
  vga_timing_gen_if b_if ();

  vga_timing_gen #(
    .H_VISIBLE(AHV), .H_FRONT(AHF), .H_SYNC(AHS), .H_BACK(AHB),
    .V_VISIBLE(AVV), .V_FRONT(AVF), .V_SYNC(AVS), .V_BACK(AVB),
    .SYNC_ACTIVE(1'b0), .PIPE_DELAY(2)
  ) dut_a (
    .vga_clk(vga_clk),
    .reset  (reset),
    .vga    (a_if.master)
  );

  vga_timing_gen #(
    .SYNC_ACTIVE(1'b1), .PIPE_DELAY(3)
  ) dut_b (
    .vga_clk(vga_clk),
    .reset  (reset),
    .vga    (b_if.master)
  );

  always #20 vga_clk = ~vga_clk;

  // Expected outputs t edges after the last reset edge: coordinates are the cycle count folded
  // into the raster; delayed outputs are the same rules applied to t - pd.
  function automatic obs_t model(int tt, int hv, int hf, int hsy, int hb,
                                 int vv, int vf, int vsy, int vb, logic sa, int pd);
    int   ht = hv + hf + hsy + hb;
    int   vt = vv + vf + vsy + vb;
    int   x, y, u, ux, uy;
    obs_t o;
    x = tt % ht;
    y = (tt / ht) % vt;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.blank = (x < hv) && (y < vv);
    o.ls    = (x == 0);
    o.fs    = (x == 0) && (y == 0);
    if (tt >= pd) begin
      u  = tt - pd;
      ux = u % ht;
      uy = (u / ht) % vt;
      o.blank_d = (ux < hv) && (uy < vv);
      o.hs = (ux >= hv + hf && ux < hv + hf + hsy) ? sa : ~sa;
      o.vs = (uy >= vv + vf && uy < vv + vf + vsy) ? sa : ~sa;
    end else begin
      o.blank_d = 1'b0;
      o.hs      = ~sa;
      o.vs      = ~sa;
    end
    return o;
  endfunction

  task automatic chk(string tag, int observed, int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, observed, expected);
    end
  endtask

  task automatic compare(string tag, obs_t o, obs_t e);
    chk({tag, "_DrawX"},       int'(o.x),       int'(e.x));
    chk({tag, "_DrawY"},       int'(o.y),       int'(e.y));
    chk({tag, "_blank"},       int'(o.blank),   int'(e.blank));
    chk({tag, "_blank_d"},     int'(o.blank_d), int'(e.blank_d));
    chk({tag, "_hs"},          int'(o.hs),      int'(e.hs));
    chk({tag, "_vs"},          int'(o.vs),      int'(e.vs));
    chk({tag, "_line_start"},  int'(o.ls),      int'(e.ls));
    chk({tag, "_frame_start"}, int'(o.fs),      int'(e.fs));
  endtask

  task automatic measure();
    if (a_if.frame_start === 1'b1) begin
      if (last_fs >= 0) begin
        chk("A_frame_interval", t - last_fs, AHT * AVT);
        chk("A_blank_per_frame", blank_cnt, AHV * AVV);
        frames++;
      end
      last_fs   = t;
      blank_cnt = 0;
    end
    if (a_if.blank === 1'b1) blank_cnt++;

    if (a_if.hs === 1'b0) run_ahs++;
    else if (run_ahs > 0) begin chk("A_hs_width", run_ahs, AHS); run_ahs = 0; end
    if (a_if.vs === 1'b0) run_avs++;
    else if (run_avs > 0) begin chk("A_vs_width", run_avs, AVS * AHT); run_avs = 0; end
    if (b_if.hs === 1'b1) run_bhs++;
    else if (run_bhs > 0) begin chk("B_hs_width", run_bhs, H_SYNC_DEF); run_bhs = 0; end
  endtask

  task automatic tick();
    obs_t oa, ob;
    @(posedge vga_clk);
    if (reset) begin
      t = 0;
      valid = 1;
    end else begin
      t++;
    end
    #1;
    if (valid) begin
      oa = {a_if.DrawX, a_if.DrawY, a_if.blank, a_if.blank_d, a_if.hs, a_if.vs,
            a_if.line_start, a_if.frame_start};
      ob = {b_if.DrawX, b_if.DrawY, b_if.blank, b_if.blank_d, b_if.hs, b_if.vs,
            b_if.line_start, b_if.frame_start};
      compare("A", oa, model(t, AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB, 1'b0, 2));
      compare("B", ob, model(t, H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF,
                             V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF, 1'b1, 3));
      if (measuring) measure();
    end
  endtask

  initial begin
    bit found;

    // Reset held three cycles, then the first free-running cycles.
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_A_DrawX", int'(a_if.DrawX), 0);
    chk("rst_A_blank", int'(a_if.blank), 1);
    chk("rst_A_blank_d", int'(a_if.blank_d), 0);
    chk("rst_A_hs", int'(a_if.hs), 1);
    chk("rst_A_vs", int'(a_if.vs), 1);
    chk("rst_A_frame_start", int'(a_if.frame_start), 1);
    chk("rst_B_hs", int'(b_if.hs), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_A_DrawX", int'(a_if.DrawX), 1);
    chk("post_rst_A_frame_start", int'(a_if.frame_start), 0);

    // Long free run: many small frames on A, about eleven full lines on B.
    measuring = 1;
    repeat (9000) tick();
    measuring = 0;
    checks++;
    assert (frames >= 3) else begin
      failures++;
      $error("FAIL A_frames_seen observed=%0d expected>=3", frames);
    end

    // Directed mid-frame reset on the small raster.
    found = 0;
    for (int i = 0; i < 2 * AHT * AVT && !found; i++) begin
      tick();
      if (a_if.DrawX === 10'd10 && a_if.DrawY === 10'd7) found = 1;
    end
    checks++;
    assert (found) else begin
      failures++;
      $error("FAIL A_reach_10_7 observed=0 expected=1");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_A_DrawX", int'(a_if.DrawX), 0);
    chk("midrst_A_DrawY", int'(a_if.DrawY), 0);
    chk("midrst_A_hs", int'(a_if.hs), 1);
    chk("midrst_A_vs", int'(a_if.vs), 1);
    chk("midrst_A_blank_d", int'(a_if.blank_d), 0);
    repeat (AHT * AVT + 5) tick();

    // Randomly placed and sized resets, model checked every cycle throughout.
    repeat (8) begin
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      reset = 1'b0;
      repeat ($urandom_range(1, 1200)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates the raster scan that drives every sprite/background renderer in the display path: pixel coordinates `DrawX`/`DrawY`, a visible-region flag `blank`, and VGA sync outputs.
- Renderers consume `DrawX`/`DrawY` with a two-cycle fetch (registered ROM read, then registered colour output). This block therefore delays `hs`, `vs` and `blank_d` by a matching pipeline depth, so that syncs leave the chip aligned with the RGB.
- Sits between the pixel-clock source and all renderers, one instance per display.

## Interface

Parameters:
- `H_VISIBLE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync width, pixels
- `H_BACK`, 48: horizontal back porch, pixels
- `V_VISIBLE`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BACK`, 33: vertical back porch, lines
- `SYNC_ACTIVE`, 1'b0: asserted level of `hs`/`vs` (0 = active-low)
- `PIPE_DELAY`, 2: cycles of delay on `hs`, `vs`, `blank_d`; legal range 1..4

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `vga_clk`  in  1  pixel clock, 25 MHz nominal
  - `reset`  in  1  synchronous, active-high
- Raster outputs:
  - `DrawX`  out  10  current horizontal count, 0..H_TOTAL-1
  - `DrawY`  out  10  current vertical count, 0..V_TOTAL-1
  - `blank`  out  1  1 = (DrawX, DrawY) inside the visible region; undelayed
  - `blank_d`  out  1  `blank` delayed PIPE_DELAY cycles
  - `hs`  out  1  horizontal sync, delayed PIPE_DELAY cycles
  - `vs`  out  1  vertical sync, delayed PIPE_DELAY cycles
- Event pulses:
  - `line_start`  out  1  one-cycle pulse when DrawX == 0
  - `frame_start`  out  1  one-cycle pulse when DrawX == 0 and DrawY == 0

## Operation

- Derived totals:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK = 800
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK = 525
  - Both totals must be ≤ 1024; elaboration fails otherwise.
- Counters: `hc` and `vc` are 10-bit registers; `DrawX` = `hc`, `DrawY` = `vc`.
  - Every cycle `hc` increments.
  - When `hc` == H_TOTAL-1: `hc` goes to 0 and `vc` increments.
  - When `vc` == V_TOTAL-1 at the same time: `vc` goes to 0.
  - No other counter states exist.
- Decodes, all purely from `hc`/`vc` with no input-to-output combinational path:
  - `blank` = (hc < H_VISIBLE) && (vc < V_VISIBLE)
  - `hs_raw` asserted for hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC) = [656, 752)
  - `vs_raw` asserted for vc in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC) = [490, 492), over the whole line
  - `line_start`, `frame_start` decoded as defined under Interface
- Delay line: `hs_raw`, `vs_raw` and `blank` each pass through a PIPE_DELAY-stage shift register. Output polarity is applied to the syncs: asserted drives SYNC_ACTIVE, deasserted drives ~SYNC_ACTIVE.
- Reset (at any point, mid-frame included): on the next edge `hc` = `vc` = 0 and every delay stage clears to deasserted. Outputs in the cycle after reset:
  - `DrawX` = 0, `DrawY` = 0
  - `blank` = 1, `blank_d` = 0
  - `hs` = `vs` = ~SYNC_ACTIVE
  - `line_start` = 1, `frame_start` = 1

## Timing

- Counters advance one step per `vga_clk`; there is no stall or enable.
- Line length is 800 cycles; frame length is 420000 cycles.
- Visible pixels per frame: 307200 cycles with `blank` = 1.
- `hs`, `vs` and `blank_d` lag their raw decodes by exactly PIPE_DELAY cycles.
- After reset release, delayed outputs reflect raw decodes starting at cycle PIPE_DELAY; before that they hold the deasserted values.
- `hs` asserted width is 96 cycles; `vs` asserted width is 1600 cycles (2 lines).

## Structure

- Package `vga_timing_pkg`:
  - default porch/sync/visible constants for 640x480@60
  - `H_TOTAL_DEF` = 800, `V_TOTAL_DEF` = 525
  - `COORD_W` = 10
- Sub-module `sync_delay`: a parameterized-depth, parameterized-width shift register with synchronous clear to a parameter reset value. It is instantiated once, 3 bits wide, carrying {hs_raw, vs_raw, blank}.

## Test plan

- Reset held 3 cycles, then released:
  - first cycle after reset: DrawX=0, DrawY=0, blank=1, blank_d=0, hs=vs=1, frame_start=1
  - next cycle: DrawX=1, frame_start=0
- Horizontal transition on line DrawY=5 (run from DrawX=639):
  - DrawX=640: blank=0
  - DrawX=656: hs_raw asserts; hs=0 two cycles later, for exactly 96 cycles
  - DrawX=752 (plus 2 cycles): hs returns to 1
- Line wrap: DrawX=799, DrawY=9 → next cycle DrawX=0, DrawY=10, line_start=1, frame_start=0.
- Frame wrap and vsync:
  - (799,524) → (0,0) with frame_start=1
  - vs=0 starts 2 cycles after (0,490) and lasts exactly 1600 cycles
- Reset mid-frame at (300,200):
  - next cycle: (0,0), hs=vs=1, blank_d=0
  - count continues normally afterwards
- Three full frames:
  - frame_start intervals are exactly 420000 cycles
  - blank=1 for 307200 cycles per frame
  - blank_d equals blank delayed by 2 in every cycle after the first 2
